// File: rtl/packet_switch_sched_pkg.sv
// Shared types and sizing helpers for the packet switch round-robin scheduler.
package packet_switch_sched_pkg;

   typedef enum logic {IDLE, XFER} sched_state_t;

   // Width of a port index; never narrower than one bit.
   function automatic int port_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/packet_switch_rr_pick.sv
// Combinational rotating-priority picker: returns the first requesting index
// after 'last', wrapping from N-1 back to 0.
module packet_switch_rr_pick
   import packet_switch_sched_pkg::*;
#(
   parameter int N = 4,
   localparam int W = port_idx_width(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         any,
   output logic [W-1:0] grant
);

   logic [N-1:0]   mask_hi;
   logic [2*N-1:0] dbl;
   int             sel;

   // Requests above 'last' fill the low half of a doubled vector and the full
   // request set fills the upper half, so the lowest set bit is the next port
   // in cyclic order, with 'last' itself taken only as a final resort.
   always_comb begin
      mask_hi = '0;
      for (int j = 0; j < N; j++) begin
         if (j > int'(last)) mask_hi[j] = 1'b1;
      end
      dbl = {req, req & mask_hi};
      sel = 0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (dbl[j]) sel = j;
      end
      any   = |req;
      grant = W'(sel % N);
   end

endmodule

// File: rtl/packet_switch_fifo_rr_sched.sv
// Packet-granular round-robin scheduler draining per-port show-ahead FIFOs
// onto one registered output stream with ready/valid backpressure.
module packet_switch_fifo_rr_sched
   import packet_switch_sched_pkg::*;
#(
   parameter int NUM_PORTS     = 4,
   parameter int DWD           = 64,
   parameter int MAX_PKT_WORDS = 256,
   localparam int PW = port_idx_width(NUM_PORTS),
   localparam int CW = $clog2(MAX_PKT_WORDS + 1)
) (
   input  logic                     clk1,
   input  logic                     rst,
   input  logic [NUM_PORTS-1:0]     fifo_empty,
   input  logic [NUM_PORTS*DWD-1:0] fifo_dout,
   input  logic [NUM_PORTS-1:0]     fifo_eop,
   output logic [NUM_PORTS-1:0]     fifo_rdreq,
   output logic                     out_valid,
   output logic [DWD-1:0]           out_data,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic [PW-1:0]            out_port,
   input  logic                     out_ready,
   output logic                     err_oversize
);

   sched_state_t   state;
   sched_state_t   state_next;
   logic [PW-1:0]  grant;
   logic [PW-1:0]  last;
   logic [PW-1:0]  pick_grant;
   logic           pick_any;
   logic [CW-1:0]  wcnt;
   logic [CW-1:0]  pop_num;
   logic           head_empty;
   logic           head_eop;
   logic [DWD-1:0] head_data;
   logic           pop;
   logic           first_word;
   logic           oversize;
   logic           pkt_end;

   packet_switch_rr_pick #(
      .N(NUM_PORTS)
   ) u_pick (
      .req   (~fifo_empty),
      .last  (last),
      .any   (pick_any),
      .grant (pick_grant)
   );

   // Select the granted FIFO's head word and status.
   always_comb begin
      head_empty = 1'b1;
      head_eop   = 1'b0;
      head_data  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant == PW'(i)) begin
            head_empty = fifo_empty[i];
            head_eop   = fifo_eop[i];
            head_data  = fifo_dout[i*DWD +: DWD];
         end
      end
   end

   // Next state, pop decision and per-port read strobes; wcnt is zero only
   // before the first word of a granted packet, so it doubles as the SOP mark.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      fifo_rdreq = '0;
      first_word = (wcnt == '0);
      pop_num    = wcnt + CW'(1);
      oversize   = 1'b0;
      pkt_end    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) state_next = XFER;
         end
         XFER: begin
            pop      = !head_empty && (!out_valid || out_ready);
            oversize = pop && !head_eop && (pop_num == CW'(MAX_PKT_WORDS));
            pkt_end  = pop && (head_eop || oversize);
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (grant == PW'(i)) fifo_rdreq[i] = pop;
            end
            if (pkt_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk1) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Grant latch, round-robin pointer and per-packet word counter.
   always_ff @(posedge clk1) begin
      if (rst) begin
         grant <= '0;
         last  <= PW'(NUM_PORTS - 1);
         wcnt  <= '0;
      end else begin
         if (state == IDLE && pick_any) begin
            grant <= pick_grant;
            wcnt  <= '0;
         end else if (pop) begin
            wcnt <= pop_num;
         end
         if (pkt_end) last <= grant;
      end
   end

   // Output register that holds each word until accepted, plus sticky error.
   always_ff @(posedge clk1) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sop      <= 1'b0;
         out_eop      <= 1'b0;
         out_port     <= '0;
         err_oversize <= 1'b0;
      end else begin
         if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head_data;
            out_sop   <= first_word;
            out_eop   <= head_eop || oversize;
            out_port  <= grant;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (oversize) err_oversize <= 1'b1;
      end
   end

endmodule

// File: tb/tb_packet_switch_fifo_rr_sched.sv
// Directed self-checking bench for the round-robin FIFO scheduler.
module tb_packet_switch_fifo_rr_sched;

   localparam int NP   = 4;
   localparam int DW   = 16;
   localparam int MAXW = 8;

   logic             clk1 = 1'b0;
   logic             rst;
   logic [NP-1:0]    fifo_empty;
   logic [NP*DW-1:0] fifo_dout;
   logic [NP-1:0]    fifo_eop;
   logic [NP-1:0]    fifo_rdreq;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             out_sop;
   logic             out_eop;
   logic [1:0]       out_port;
   logic             out_ready;
   logic             err_oversize;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW:0]   mem [NP][64];
   int            wr_ptr [NP] = '{default: 0};
   int            rd_ptr [NP] = '{default: 0};
   int            cyc   = 0;
   int            log_n = 0;
   int            pop_n = 0;
   logic [DW-1:0] log_data [256];
   logic          log_sop  [256];
   logic          log_eop  [256];
   logic [1:0]    log_port [256];
   int            log_cyc  [256];
   logic [NP-1:0] pop_req  [256];
   int            pop_cyc  [256];

   packet_switch_fifo_rr_sched #(
      .NUM_PORTS     (NP),
      .DWD           (DW),
      .MAX_PKT_WORDS (MAXW)
   ) dut (
      .clk1         (clk1),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_dout    (fifo_dout),
      .fifo_eop     (fifo_eop),
      .fifo_rdreq   (fifo_rdreq),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_port     (out_port),
      .out_ready    (out_ready),
      .err_oversize (err_oversize)
   );

   always #5 clk1 = ~clk1;

   // Show-ahead FIFO models: head word is visible whenever not empty.
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         fifo_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
         fifo_eop[i]           = mem[i][6'(rd_ptr[i])][DW];
         fifo_dout[i*DW +: DW] = mem[i][6'(rd_ptr[i])][DW-1:0];
      end
   end

   // FIFO pops plus logs of accepted output words and read strobes.
   always @(posedge clk1) begin
      if (!rst) begin
         for (int i = 0; i < NP; i++) begin
            if (fifo_rdreq[i]) rd_ptr[i] <= rd_ptr[i] + 1;
         end
         if (out_valid && out_ready && log_n < 256) begin
            log_data[log_n] <= out_data;
            log_sop[log_n]  <= out_sop;
            log_eop[log_n]  <= out_eop;
            log_port[log_n] <= out_port;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
         end
         if (fifo_rdreq != '0 && pop_n < 256) begin
            pop_req[pop_n] <= fifo_rdreq;
            pop_cyc[pop_n] <= cyc;
            pop_n          <= pop_n + 1;
         end
      end
      cyc <= cyc + 1;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push(input int p, input logic [DW-1:0] d, input logic e);
      mem[p][6'(wr_ptr[p])] = {e, d};
      wr_ptr[p] = wr_ptr[p] + 1;
   endtask

   function automatic logic [DW-1:0] wd(input int p, input int k, input int w);
      return {4'(p), 4'(k), 8'(w)};
   endfunction

   function automatic logic [DW+3:0] ew(input int p, input logic s, input logic e,
                                        input logic [DW-1:0] d);
      return {2'(p), s, e, d};
   endfunction

   task automatic wait_accepts(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk1);
         if (log_n >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (fifo_rdreq !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_rdreq: got %b want 0000", fifo_rdreq); end
      n_checks++; if (out_sop !== 1'b0 || out_eop !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sop_eop: got %b%b want 00", out_sop, out_eop); end
      n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h want 0000", out_data); end
      n_checks++; if (out_port !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_out_port: got %0d want 0", out_port); end
      n_checks++; if (err_oversize !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err_oversize); end
      rst = 1'b0;
   endtask

   task automatic test_single_port();
      int base_l, base_p, k;
      bit ok;
      @(negedge clk1);
      base_l = log_n; base_p = pop_n; k = cyc;
      for (int i = 0; i < 4; i++) push(0, wd(0, 0, i), i == 3);
      wait_accepts(base_l + 4, 30, ok);
      repeat (3) @(negedge clk1);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL single_timeout: got %0d words want 4", log_n - base_l); end
      n_checks++; if (pop_n - base_p != 4) begin n_fail++; $display("[TB] FAIL single_pop_count: got %0d want 4", pop_n - base_p); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (pop_req[base_p+i] !== 4'b0001 || pop_cyc[base_p+i] != k + 1 + i) begin
            n_fail++; $display("[TB] FAIL single_pop[%0d]: got req %b cyc %0d want 0001 cyc %0d", i, pop_req[base_p+i], pop_cyc[base_p+i], k + 1 + i);
         end
         n_checks++;
         if ({log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]} !== ew(0, i == 0, i == 3, wd(0, 0, i))) begin
            n_fail++; $display("[TB] FAIL single_word[%0d]: got %h want %h", i, {log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]}, ew(0, i == 0, i == 3, wd(0, 0, i)));
         end
      end
   endtask

   task automatic test_fairness();
      int base_l, k, idx;
      bit ok;
      @(negedge clk1); rst = 1'b1;
      @(negedge clk1); rst = 1'b0;
      base_l = log_n; k = cyc;
      for (int n = 0; n < 2; n++)
         for (int p = 0; p < NP; p++)
            for (int w = 0; w < 2; w++) push(p, wd(p, n + 1, w), w == 1);
      wait_accepts(base_l + 16, 60, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL fair_timeout: got %0d words want 16", log_n - base_l); end
      for (int j = 0; j < 8; j++) begin
         for (int w = 0; w < 2; w++) begin
            idx = base_l + 2*j + w;
            n_checks++;
            if ({log_port[idx], log_sop[idx], log_eop[idx], log_data[idx]} !== ew(j % NP, w == 0, w == 1, wd(j % NP, j / NP + 1, w))) begin
               n_fail++; $display("[TB] FAIL fair_word[%0d]: got %h want %h", 2*j + w, {log_port[idx], log_sop[idx], log_eop[idx], log_data[idx]}, ew(j % NP, w == 0, w == 1, wd(j % NP, j / NP + 1, w)));
            end
         end
         n_checks++;
         if (log_cyc[base_l + 2*j] != k + 2 + 3*j) begin
            n_fail++; $display("[TB] FAIL fair_timing[%0d]: got cyc %0d want %0d", j, log_cyc[base_l + 2*j], k + 2 + 3*j);
         end
      end
   endtask

   task automatic test_backpressure();
      int base_l;
      @(negedge clk1);
      base_l = log_n;
      for (int i = 0; i < 6; i++) push(0, wd(0, 3, i), i == 5);
      for (int i = 0; i < 25; i++) begin
         @(negedge clk1);
         out_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
         #1;
         if (i == 3 || i == 4) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== wd(0, 3, 2)) begin n_fail++; $display("[TB] FAIL bp_hold[%0d]: got v %b data %h want v 1 data %h", i, out_valid, out_data, wd(0, 3, 2)); end
            n_checks++; if (fifo_rdreq !== 4'b0000) begin n_fail++; $display("[TB] FAIL bp_no_pop[%0d]: got %b want 0000", i, fifo_rdreq); end
         end
      end
      out_ready = 1'b1;
      n_checks++; if (log_n - base_l != 6) begin n_fail++; $display("[TB] FAIL bp_count: got %0d want 6", log_n - base_l); end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if ({log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]} !== ew(0, i == 0, i == 5, wd(0, 3, i))) begin
            n_fail++; $display("[TB] FAIL bp_word[%0d]: got %h want %h", i, {log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]}, ew(0, i == 0, i == 5, wd(0, 3, i)));
         end
      end
   endtask

   task automatic test_starvation();
      int base_l, p, w;
      bit ok;
      @(negedge clk1);
      base_l = log_n;
      push(1, wd(1, 4, 0), 1'b0);
      push(1, wd(1, 4, 1), 1'b0);
      push(2, wd(2, 4, 0), 1'b0);
      push(2, wd(2, 4, 1), 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk1);
         if (i >= 3) begin
            n_checks++; if (fifo_rdreq !== 4'b0000) begin n_fail++; $display("[TB] FAIL starve_stall[%0d]: got %b want 0000", i, fifo_rdreq); end
         end
      end
      for (int i = 2; i < 5; i++) push(1, wd(1, 4, i), i == 4);
      wait_accepts(base_l + 7, 30, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL starve_timeout: got %0d words want 7", log_n - base_l); end
      for (int i = 0; i < 7; i++) begin
         p = (i < 5) ? 1 : 2;
         w = (i < 5) ? i : i - 5;
         n_checks++;
         if ({log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]} !== ew(p, w == 0, (i == 4 || i == 6), wd(p, 4, w))) begin
            n_fail++; $display("[TB] FAIL starve_word[%0d]: got %h want %h", i, {log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]}, ew(p, w == 0, (i == 4 || i == 6), wd(p, 4, w)));
         end
      end
   endtask

   task automatic test_oversize();
      int base_l, base_p, k;
      bit ok, seen7, done;
      @(negedge clk1);
      n_checks++; if (err_oversize !== 1'b0) begin n_fail++; $display("[TB] FAIL ovs_err_before: got %b want 0", err_oversize); end
      base_l = log_n; base_p = pop_n; k = cyc;
      for (int i = 0; i < 10; i++) push(3, wd(3, 5, i), i == 9);
      seen7 = 1'b0; done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk1);
         if (pop_n - base_p == 7 && !seen7) begin
            seen7 = 1'b1;
            n_checks++; if (err_oversize !== 1'b0) begin n_fail++; $display("[TB] FAIL ovs_err_early: got %b want 0", err_oversize); end
         end
         if (pop_n - base_p >= 8) begin
            done = 1'b1;
            n_checks++; if (err_oversize !== 1'b1) begin n_fail++; $display("[TB] FAIL ovs_err_set: got %b want 1", err_oversize); end
            break;
         end
      end
      n_checks++; if (!done || !seen7) begin n_fail++; $display("[TB] FAIL ovs_pop_progress: got seen7 %b done %b want 1 1", seen7, done); end
      wait_accepts(base_l + 10, 40, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL ovs_timeout: got %0d words want 10", log_n - base_l); end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if ({log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]} !== ew(3, (i == 0 || i == 8), (i == 7 || i == 9), wd(3, 5, i))) begin
            n_fail++; $display("[TB] FAIL ovs_word[%0d]: got %h want %h", i, {log_port[base_l+i], log_sop[base_l+i], log_eop[base_l+i], log_data[base_l+i]}, ew(3, (i == 0 || i == 8), (i == 7 || i == 9), wd(3, 5, i)));
         end
      end
      n_checks++; if (pop_cyc[base_p+8] != k + 10) begin n_fail++; $display("[TB] FAIL ovs_tail_timing: got cyc %0d want %0d", pop_cyc[base_p+8], k + 10); end
      n_checks++; if (err_oversize !== 1'b1) begin n_fail++; $display("[TB] FAIL ovs_err_sticky: got %b want 1", err_oversize); end
   endtask

   task automatic test_reset_mid();
      int base_l, base_p, k;
      bit ok, hit;
      @(negedge clk1);
      base_p = pop_n;
      for (int i = 0; i < 6; i++) push(1, wd(1, 6, i), i == 5);
      push(2, wd(2, 6, 0), 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk1);
         if (pop_n - base_p >= 2) begin
            hit = 1'b1;
            break;
         end
      end
      n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL rstmid_progress: got %0d pops want 2", pop_n - base_p); end
      rst = 1'b1;
      @(negedge clk1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_out_valid: got %b want 0", out_valid); end
      n_checks++; if (fifo_rdreq !== 4'b0000) begin n_fail++; $display("[TB] FAIL rstmid_rdreq: got %b want 0000", fifo_rdreq); end
      n_checks++; if (err_oversize !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_err: got %b want 0", err_oversize); end
      n_checks++; if ({out_sop, out_eop, out_port, out_data} !== 20'h00000) begin n_fail++; $display("[TB] FAIL rstmid_outputs: got %h want 00000", {out_sop, out_eop, out_port, out_data}); end
      rst = 1'b0;
      base_l = log_n; base_p = pop_n; k = cyc;
      wait_accepts(base_l + 5, 30, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL rstmid_timeout: got %0d words want 5", log_n - base_l); end
      n_checks++; if (pop_req[base_p] !== 4'b0010 || pop_cyc[base_p] != k + 1) begin n_fail++; $display("[TB] FAIL rstmid_first_grant: got req %b cyc %0d want 0010 cyc %0d", pop_req[base_p], pop_cyc[base_p], k + 1); end
      n_checks++; if ({log_port[base_l], log_sop[base_l], log_eop[base_l], log_data[base_l]} !== ew(1, 1'b1, 1'b0, wd(1, 6, 2))) begin n_fail++; $display("[TB] FAIL rstmid_word0: got %h want %h", {log_port[base_l], log_sop[base_l], log_eop[base_l], log_data[base_l]}, ew(1, 1'b1, 1'b0, wd(1, 6, 2))); end
      n_checks++; if ({log_port[base_l+3], log_sop[base_l+3], log_eop[base_l+3], log_data[base_l+3]} !== ew(1, 1'b0, 1'b1, wd(1, 6, 5))) begin n_fail++; $display("[TB] FAIL rstmid_word3: got %h want %h", {log_port[base_l+3], log_sop[base_l+3], log_eop[base_l+3], log_data[base_l+3]}, ew(1, 1'b0, 1'b1, wd(1, 6, 5))); end
      n_checks++; if ({log_port[base_l+4], log_sop[base_l+4], log_eop[base_l+4], log_data[base_l+4]} !== ew(2, 1'b1, 1'b1, wd(2, 6, 0))) begin n_fail++; $display("[TB] FAIL rstmid_word4: got %h want %h", {log_port[base_l+4], log_sop[base_l+4], log_eop[base_l+4], log_data[base_l+4]}, ew(2, 1'b1, 1'b1, wd(2, 6, 0))); end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      test_reset();
      test_single_port();
      test_fairness();
      test_backpressure();
      test_starvation();
      test_oversize();
      test_reset_mid();
      repeat (2) @(negedge clk1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
